// File: rtl/wb_irq_ctrl_n.sv
// wb_irq_ctrl_n: interrupt controller for NUM_SRC device lines with a Wishbone
// register slave (PENDING / MASK / MODE / STATUS+EOI).
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   dat_i, adr_i, we_i,   Wishbone slave inputs (adr_i[3:2] selects the register)
//   stb_i
//   dat_o, ack_o          Wishbone read data and one-cycle acknowledge
//   intrrupt_en           CPU global interrupt enable
//   m0_irq_o, m0_iack_i   request to / level acknowledge from the CPU
//   gnt_o, irq_id_o       one-hot grant and index of the granted source
//   irq_i                 asynchronous device interrupt lines
//   iack_o                one-hot single-cycle device acknowledge
//
// Build option: define IRQ_ROUND_ROBIN_EN for rotating priority; the default
// build arbitrates with fixed priority (lowest index wins).
module wb_irq_ctrl_n #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        dat_i,
    input  logic [31:0]        adr_i,
    input  logic               we_i,
    input  logic               stb_i,
    output logic [31:0]        dat_o,
    output logic               ack_o,
    input  logic               intrrupt_en,
    output logic               m0_irq_o,
    input  logic               m0_iack_i,
    output logic [NUM_SRC-1:0] gnt_o,
    output logic [ID_W-1:0]    irq_id_o,
    input  logic [NUM_SRC-1:0] irq_i,
    output logic [NUM_SRC-1:0] iack_o
);

    typedef enum logic [1:0] {IDLE, REQ, ACK, SVC} state_t;
    state_t state;

    logic [NUM_SRC-1:0] sync1, sync2, prev, rise;
    logic [NUM_SRC-1:0] pend_reg, pend_nxt, pending;
    logic [NUM_SRC-1:0] mask, mode, in_service, eligible;
    logic               bus_cyc, wr, eoi, busy;
    logic [1:0]         reg_sel;
    logic [31:0]        rd_data;
    logic [ID_W-1:0]    win_id;
    logic               unused_bits;

    // Only adr_i[3:2] and the low NUM_SRC data bits are meaningful.
    assign unused_bits = ^{adr_i[31:4], adr_i[1:0], dat_i};

    assign bus_cyc  = stb_i & ~ack_o;
    assign wr       = bus_cyc & we_i;
    assign reg_sel  = adr_i[3:2];
    assign eoi      = wr && (reg_sel == 2'd3);
    assign busy     = (state == SVC);
    assign rise     = sync2 & ~prev;
    assign pending  = (pend_reg & mode) | (sync2 & ~mode);
    assign eligible = pending & mask & ~in_service;

    // Two-flop synchroniser plus edge-detect history.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= irq_i;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Edge-mode latch: W1C and ACK clear, a fresh edge in the same cycle wins.
    always_comb begin
        pend_nxt = pend_reg;
        if (wr && reg_sel == 2'd0) begin
            pend_nxt = pend_nxt & ~dat_i[NUM_SRC-1:0];
        end
        if (state == ACK) begin
            pend_nxt = pend_nxt & ~gnt_o;
        end
        pend_nxt = (pend_nxt | rise) & mode;
    end

    // Register read mux.
    always_comb begin
        case (reg_sel)
            2'd0:    rd_data = 32'(pending);
            2'd1:    rd_data = 32'(mask);
            2'd2:    rd_data = 32'(mode);
            default: rd_data = {busy, 31'(irq_id_o)};
        endcase
    end

    // Wishbone slave and configuration registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o    <= 1'b0;
            dat_o    <= '0;
            mask     <= '0;
            mode     <= '0;
            pend_reg <= '0;
        end else begin
            ack_o    <= bus_cyc;
            dat_o    <= bus_cyc ? rd_data : 32'd0;
            pend_reg <= pend_nxt;
            if (wr && reg_sel == 2'd1) begin
                mask <= dat_i[NUM_SRC-1:0];
            end
            if (wr && reg_sel == 2'd2) begin
                mode <= dat_i[NUM_SRC-1:0];
            end
        end
    end

`ifdef IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0]    ptr;
    logic [NUM_SRC-1:0] rot;
    int unsigned        off, sum;

    // Rotate so the search starts at ptr, then map the offset back to an index.
    always_comb begin
        rot = NUM_SRC'({eligible, eligible} >> ptr);
        off = 0;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (rot[i-1]) begin
                off = i - 1;
            end
        end
        sum = 32'(ptr) + off;
        if (sum >= NUM_SRC) begin
            sum = sum - NUM_SRC;
        end
        win_id = ID_W'(sum);
    end

    // Pointer moves past the source that was just acknowledged.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr <= '0;
        end else if (state == ACK) begin
            ptr <= (32'(irq_id_o) + 32'd1 >= NUM_SRC) ? '0 : irq_id_o + 1'b1;
        end
    end
`else
    // Fixed priority: lowest eligible index.
    always_comb begin
        win_id = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (eligible[i-1]) begin
                win_id = ID_W'(i - 1);
            end
        end
    end
`endif

    // Request / acknowledge / service sequencing with registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            m0_irq_o   <= 1'b0;
            gnt_o      <= '0;
            irq_id_o   <= '0;
            iack_o     <= '0;
            in_service <= '0;
        end else begin
            iack_o <= '0;
            case (state)
                IDLE: begin
                    if (intrrupt_en && (eligible != '0)) begin
                        gnt_o    <= NUM_SRC'(1) << win_id;
                        irq_id_o <= win_id;
                        m0_irq_o <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (!intrrupt_en) begin
                        m0_irq_o <= 1'b0;
                        gnt_o    <= '0;
                        irq_id_o <= '0;
                        state    <= IDLE;
                    end else if (m0_iack_i) begin
                        m0_irq_o <= 1'b0;
                        iack_o   <= gnt_o;
                        state    <= ACK;
                    end
                end
                ACK: begin
                    in_service <= gnt_o;
                    state      <= SVC;
                end
                SVC: begin
                    if (eoi) begin
                        in_service <= '0;
                        gnt_o      <= '0;
                        irq_id_o   <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_irq_ctrl_n.sv
// Self-checking bench for wb_irq_ctrl_n (NUM_SRC=8, ID_W=3): reset, directed
// corner sequences, a vector table for arbitration, and randomized edge-mode
// traffic checked against a set-based reference model.
module tb_wb_irq_ctrl_n;
    localparam int N = 8;

    logic          clk, rst, we, stb, intr_en, iack_cpu;
    logic [31:0]   wdat, adr, rdat;
    logic          ack, m0_irq;
    logic [N-1:0]  gnt, irq, iack;
    logic [2:0]    irq_id;

    wb_irq_ctrl_n #(.NUM_SRC(8), .ID_W(3)) dut (
        .clk_i(clk), .rst_i(rst), .dat_i(wdat), .adr_i(adr), .we_i(we),
        .stb_i(stb), .dat_o(rdat), .ack_o(ack), .intrrupt_en(intr_en),
        .m0_irq_o(m0_irq), .m0_iack_i(iack_cpu), .gnt_o(gnt),
        .irq_id_o(irq_id), .irq_i(irq), .iack_o(iack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;
    logic [31:0]  rd_at_ack;
    logic [N-1:0] gnt_at_ack;

    typedef struct {
        logic [N-1:0] mask;
        logic [N-1:0] lines;
        int           id;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int id);
        logic [N-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Reference arbitration: scan indices from the start point, first hit wins.
    function automatic int pick(input logic [N-1:0] elig);
        int start;
`ifdef IRQ_ROUND_ROBIN_EN
        start = m_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (elig[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // One Wishbone access; starts and ends on a falling edge.
    task automatic wb(input logic w, input logic [1:0] a, input logic [31:0] d);
        stb = 1'b1; we = w; adr = {28'h0, a, 2'b00}; wdat = d;
        @(posedge clk); @(negedge clk);
        chk("wb_ack", 32'(ack), 32'd1);
        rd_at_ack  = rdat;
        gnt_at_ack = gnt;
        stb = 1'b0; we = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("wb_ack_drop", 32'(ack), 32'd0);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (m0_irq !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 32'(m0_irq), 32'd1);
    endtask

    // CPU acknowledge handshake for the source expected to be granted.
    task automatic serve(input int id);
        iack_cpu = 1'b1;
        @(negedge clk);
        chk("iack_pulse", 32'(iack), 32'(onehot(id)));
        iack_cpu = 1'b0;
        @(negedge clk);
        chk("iack_one_cycle", 32'(iack), 32'd0);
        chk("irq_low_in_svc", 32'(m0_irq), 32'd0);
        m_ptr = (id + 1) % N;
    endtask

    task automatic pulse(input logic [N-1:0] p);
        irq = p;
        @(negedge clk);
        irq = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] mask_r, pulses, m_pend;
        int exp_id;

        tbl[0] = '{8'hFF, 8'h80, 7};
        tbl[1] = '{8'hFF, 8'h81, 0};
        tbl[2] = '{8'hFE, 8'h81, 7};
        tbl[3] = '{8'hF0, 8'h3C, 4};
        tbl[4] = '{8'h0C, 8'hFF, 2};
        tbl[5] = '{8'h40, 8'h60, 6};

        rst = 1'b0; we = 1'b0; stb = 1'b0; wdat = '0; adr = '0;
        intr_en = 1'b1; iack_cpu = 1'b0; irq = '0;
        repeat (2) @(negedge clk);
        chk("rst_irq", 32'(m0_irq), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_iack", 32'(iack), 32'd0);
        chk("rst_dat", rdat, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Register reads after reset.
        for (int r = 0; r < 4; r++) begin
            wb(1'b0, 2'(r), 32'd0);
            chk("reset_reg", rd_at_ack, 32'd0);
        end
        chk("reset_no_req", 32'(m0_irq), 32'd0);

        // Edge source 0, four-edge request latency.
        wb(1'b1, 2'd1, 32'hFF);
        wb(1'b1, 2'd2, 32'h01);
        pulse(8'h01);
        @(negedge clk); @(negedge clk);
        chk("edge_lat_e3", 32'(m0_irq), 32'd0);
        @(negedge clk);
        chk("edge_lat_e4", 32'(m0_irq), 32'd1);
        chk("edge_gnt", 32'(gnt), 32'h01);
        chk("edge_id", 32'(irq_id), 32'd0);
        serve(0);
        wb(1'b0, 2'd0, 32'd0);
        chk("edge_pend_clr", rd_at_ack, 32'd0);
        wb(1'b0, 2'd3, 32'd0);
        chk("status_busy", rd_at_ack, 32'h8000_0000);
        wb(1'b1, 2'd3, 32'd0);
        chk("eoi_gnt", 32'(gnt_at_ack), 32'd0);
        chk("eoi_idle", 32'(m0_irq), 32'd0);

        // Level sources 2 and 5 held.
        wb(1'b1, 2'd2, 32'h00);
        irq = 8'h24;
        wait_req(8);
        exp_id = pick(8'h24);
        chk("lvl_id1", 32'(irq_id), 32'(exp_id));
        serve(exp_id);
        wb(1'b1, 2'd3, 32'd0);
        exp_id = pick(8'h24);
        wait_req(4);
        chk("lvl_id2", 32'(irq_id), 32'(exp_id));
        chk("lvl_gnt2", 32'(gnt), 32'(onehot(exp_id)));
        serve(exp_id);
        irq = '0;
        repeat (4) @(negedge clk);
        wb(1'b1, 2'd3, 32'd0);
        repeat (3) @(negedge clk);
        chk("lvl_quiet", 32'(m0_irq), 32'd0);

        // Global enable, EOI outside SVC, mask change and level drop in REQ.
        intr_en = 1'b0;
        irq = 8'h08;
        repeat (6) @(negedge clk);
        chk("en_off_no_req", 32'(m0_irq), 32'd0);
        intr_en = 1'b1;
        @(negedge clk);
        chk("en_on_req", 32'(m0_irq), 32'd1);
        chk("en_on_id", 32'(irq_id), 32'd3);
        intr_en = 1'b0;
        @(negedge clk);
        chk("en_drop_req", 32'(m0_irq), 32'd0);
        chk("en_drop_gnt", 32'(gnt), 32'd0);
        intr_en = 1'b1;
        @(negedge clk);
        chk("en_again", 32'(m0_irq), 32'd1);
        wb(1'b1, 2'd3, 32'd0);
        chk("eoi_in_req_ignored", 32'(m0_irq), 32'd1);
        wb(1'b1, 2'd1, 32'h00);
        chk("mask_keeps_gnt", 32'(gnt), 32'h08);
        irq = '0;
        repeat (4) @(negedge clk);
        chk("lvl_drop_keeps_req", 32'(m0_irq), 32'd1);
        wb(1'b0, 2'd0, 32'd0);
        chk("spurious_pend", rd_at_ack, 32'd0);
        serve(3);
        wb(1'b1, 2'd3, 32'd0);
        repeat (3) @(negedge clk);
        chk("after_spurious", 32'(m0_irq), 32'd0);
        wb(1'b1, 2'd1, 32'hFF);

        // Edge set beats W1C on the same edge; masked source; re-pend in service.
        intr_en = 1'b0;
        wb(1'b1, 2'd2, 32'h02);
        pulse(8'h02);
        repeat (4) @(negedge clk);
        wb(1'b0, 2'd0, 32'd0);
        chk("edge1_pend", rd_at_ack, 32'h02);
        irq = 8'h02;
        @(negedge clk);
        irq = '0;
        @(negedge clk);
        wb(1'b1, 2'd0, 32'h02);
        wb(1'b0, 2'd0, 32'd0);
        chk("set_wins_w1c", rd_at_ack, 32'h02);
        wb(1'b1, 2'd0, 32'h02);
        wb(1'b0, 2'd0, 32'd0);
        chk("w1c_clears", rd_at_ack, 32'd0);
        wb(1'b1, 2'd1, 32'hFD);
        pulse(8'h02);
        intr_en = 1'b1;
        repeat (8) @(negedge clk);
        chk("masked_no_req", 32'(m0_irq), 32'd0);
        wb(1'b1, 2'd1, 32'hFF);
        wait_req(4);
        chk("unmasked_id", 32'(irq_id), 32'd1);
        serve(1);
        pulse(8'h02);
        repeat (4) @(negedge clk);
        wb(1'b0, 2'd0, 32'd0);
        chk("repend_in_svc", rd_at_ack, 32'h02);
        wb(1'b1, 2'd3, 32'd0);
        wait_req(4);
        chk("repend_served", 32'(irq_id), 32'd1);
        serve(1);
        wb(1'b1, 2'd3, 32'd0);

        // Arbitration vector table, level mode.
        wb(1'b1, 2'd2, 32'h00);
        for (int v = 0; v < 6; v++) begin
`ifdef IRQ_ROUND_ROBIN_EN
            exp_id = pick(tbl[v].mask & tbl[v].lines);
`else
            exp_id = tbl[v].id;
`endif
            wb(1'b1, 2'd1, 32'(tbl[v].mask));
            irq = tbl[v].lines;
            wait_req(8);
            chk("tbl_id", 32'(irq_id), 32'(exp_id));
            chk("tbl_gnt", 32'(gnt), 32'(onehot(exp_id)));
            serve(exp_id);
            irq = '0;
            repeat (4) @(negedge clk);
            wb(1'b1, 2'd3, 32'd0);
            repeat (3) @(negedge clk);
            chk("tbl_quiet", 32'(m0_irq), 32'd0);
        end

        // Randomized edge-mode bursts against the set model.
        wb(1'b1, 2'd2, 32'hFF);
        for (int it = 0; it < 20; it++) begin
            mask_r = 8'($urandom_range(1, 255));
            wb(1'b1, 2'd1, 32'(mask_r));
            pulses = 8'($urandom);
            pulse(pulses);
            repeat (3) @(negedge clk);
            m_pend = pulses;
            wb(1'b0, 2'd0, 32'd0);
            chk("rnd_pending", rd_at_ack, 32'(m_pend));
            while ((m_pend & mask_r) != '0) begin
                exp_id = pick(m_pend & mask_r);
                wait_req(10);
                chk("rnd_id", 32'(irq_id), 32'(exp_id));
                chk("rnd_gnt", 32'(gnt), 32'(onehot(exp_id)));
                serve(exp_id);
                m_pend[exp_id] = 1'b0;
                wb(1'b1, 2'd3, 32'd0);
                chk("rnd_eoi_gnt", 32'(gnt_at_ack), 32'd0);
            end
            repeat (3) @(negedge clk);
            chk("rnd_idle", 32'(m0_irq), 32'd0);
            wb(1'b1, 2'd0, 32'hFF);
        end

        // Asynchronous reset while in service.
        wb(1'b1, 2'd1, 32'hFF);
        wb(1'b1, 2'd2, 32'h00);
        irq = 8'h04;
        wait_req(8);
        serve(pick(8'h04));
        chk("svc_gnt", 32'(gnt), 32'h04);
        #1 rst = 1'b0;
        #1;
        chk("arst_irq", 32'(m0_irq), 32'd0);
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_id", 32'(irq_id), 32'd0);
        chk("arst_iack", 32'(iack), 32'd0);
        chk("arst_ack", 32'(ack), 32'd0);
        chk("arst_dat", rdat, 32'd0);
        irq = '0;
        m_ptr = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wb(1'b0, 2'd1, 32'd0);
        chk("arst_mask", rd_at_ack, 32'd0);
        wb(1'b0, 2'd2, 32'd0);
        chk("arst_mode", rd_at_ack, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
